// File: rtl/control_mc.sv
// Multicycle RV32I control FSM: FETCH/DECODE/MEM/EXEC with memory handshake stalls,
// optional MEM bypass, sticky HALT/TRAP states and a retired-instruction counter.
module control_mc #(
  parameter bit          SKIP_MEM     = 1'b1,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter bit          ILLEGAL_TRAP = 1'b1,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 bit20,
  input  logic                 bit30,
  input  logic                 cmp_out,
  input  logic                 mem_ready,
  output logic                 halt,
  output logic                 trap,
  output logic                 pc_enable,
  output logic                 pc_load,
  output logic                 reg_re1,
  output logic                 reg_re2,
  output logic                 reg_we,
  output logic                 alu_sel1,
  output logic                 alu_sel2,
  output logic [4:0]           alu_op,
  output logic                 target_load,
  output logic [1:0]           wd_sel,
  output logic                 mem_addr_sel,
  output logic [2:0]           mem_read_op,
  output logic [1:0]           mem_write_op,
  output logic                 inst_load,
  output logic                 inst_mux_sel,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [2:0] LW    = 3'b010;
  localparam logic [2:0] LNONE = 3'b111;
  localparam logic [1:0] SNONE = 2'b11;

  localparam int unsigned SCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_HALT,
    S_TRAP
  } state_t;

  state_t               state_q, state_d;
  logic [SCW-1:0]       stall_q, stall_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic is_op_imm, is_op, is_system, is_misc_mem;
  logic legal, halt_cond, mem_access, timeout_hit;

  always_comb begin
    is_lui      = (opcode == OPC_LUI);
    is_auipc    = (opcode == OPC_AUIPC);
    is_jal      = (opcode == OPC_JAL);
    is_jalr     = (opcode == OPC_JALR);
    is_branch   = (opcode == OPC_BRANCH);
    is_load     = (opcode == OPC_LOAD);
    is_store    = (opcode == OPC_STORE);
    is_op_imm   = (opcode == OPC_OP_IMM);
    is_op       = (opcode == OPC_OP);
    is_system   = (opcode == OPC_SYSTEM);
    is_misc_mem = (opcode == OPC_MISC_MEM);
    legal       = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                  is_op_imm | is_op | is_system | is_misc_mem;
    halt_cond   = is_system & bit20;
    mem_access  = is_load | is_store;
    // Stall cycle that would be number MEM_TIMEOUT; a simultaneous mem_ready still advances.
    timeout_hit = (MEM_TIMEOUT != 0) && (stall_q == SCW'(MEM_TIMEOUT - 1));
  end

  always_comb begin
    if (is_load)               wd_sel = 2'b11;
    else if (is_jal | is_jalr) wd_sel = 2'b01;
    else                       wd_sel = 2'b00;
  end

  always_comb begin
    state_d      = state_q;
    stall_d      = '0;
    instret_d    = instret_q;
    halt         = 1'b0;
    trap         = 1'b0;
    pc_enable    = 1'b0;
    pc_load      = 1'b0;
    reg_re1      = 1'b0;
    reg_re2      = 1'b0;
    reg_we       = 1'b0;
    alu_sel1     = 1'b0;
    alu_sel2     = 1'b0;
    alu_op       = '0;
    target_load  = 1'b0;
    mem_addr_sel = 1'b0;
    mem_read_op  = LNONE;
    mem_write_op = SNONE;
    inst_load    = 1'b0;
    inst_mux_sel = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_op = LW;
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_TRAP;
        else                  stall_d = stall_q + 1'b1;
      end
      S_DECODE: begin
        reg_re1     = 1'b1;
        reg_re2     = 1'b1;
        inst_load   = 1'b1;
        target_load = 1'b1;
        alu_sel1    = 1'b1;
        alu_sel2    = 1'b1;
        if (ILLEGAL_TRAP && !legal)                   state_d = S_TRAP;
        else if (!SKIP_MEM || mem_access || is_jalr) state_d = S_MEM;
        else                                          state_d = S_EXEC;
      end
      S_MEM: begin
        mem_addr_sel = 1'b1;
        inst_mux_sel = 1'b1;
        if (is_load)  mem_read_op  = funct3;
        if (is_store) mem_write_op = funct3[1:0];
        if (is_jalr)  target_load  = 1'b1;
        if (mem_access | is_jalr) alu_sel2 = 1'b1;
        if (!mem_access || mem_ready) state_d = S_EXEC;
        else if (timeout_hit)         state_d = S_TRAP;
        else                          stall_d = stall_q + 1'b1;
      end
      S_EXEC: begin
        inst_mux_sel = 1'b1;
        reg_we       = is_op_imm | is_lui | is_op | is_auipc | is_jal | is_jalr | is_load;
        pc_enable    = ~halt_cond;
        pc_load      = is_jal | is_jalr | (is_branch & cmp_out);
        if (is_auipc) begin
          alu_sel1 = 1'b1;
          alu_sel2 = 1'b1;
        end else if (is_op_imm | is_lui) begin
          alu_sel2 = 1'b1;
        end
        if (is_op || (is_op_imm && funct3 == 3'b101)) alu_op = {1'b0, bit30, funct3};
        else if (is_op_imm)                           alu_op = {2'b00, funct3};
        else if (is_branch)                           alu_op = {2'b10, funct3};
        if (halt_cond) begin
          state_d = S_HALT;
        end else begin
          state_d   = S_FETCH;
          instret_d = instret_q + 1'b1;
        end
      end
      S_HALT:  halt = 1'b1;
      S_TRAP:  trap = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      stall_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_control_mc.sv
// Directed bench for control_mc: two instances (default and MEM/timeout/NOP/wrap variant),
// expected control vectors queued per cycle and compared at mid-cycle.
module tb_control_mc;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_ILL    = 7'h7F;
  localparam logic [2:0] LW        = 3'b010;
  localparam logic [2:0] LNONE     = 3'b111;
  localparam logic [1:0] SNONE     = 2'b11;

  typedef struct packed {
    logic       halt;
    logic       trap;
    logic       pc_enable;
    logic       pc_load;
    logic       reg_re1;
    logic       reg_re2;
    logic       reg_we;
    logic       alu_sel1;
    logic       alu_sel2;
    logic [4:0] alu_op;
    logic       target_load;
    logic [1:0] wd_sel;
    logic       mem_addr_sel;
    logic [2:0] mem_read_op;
    logic [1:0] mem_write_op;
    logic       inst_load;
    logic       inst_mux_sel;
  } ctl_t;

  typedef struct {
    string       tag;
    bit          on_b;
    ctl_t        exp;
    logic [31:0] cnt;
  } sb_t;

  logic       clk = 1'b0;
  logic       a_rst, b_rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit20, bit30, cmp_out, mem_ready;

  logic        a_halt, a_trap, a_pce, a_pcl, a_re1, a_re2, a_we, a_as1, a_as2, a_tl;
  logic        a_mas, a_il, a_ims;
  logic [4:0]  a_aop;
  logic [1:0]  a_wd, a_mwo;
  logic [2:0]  a_mro;
  logic [31:0] a_cnt;
  logic        b_halt, b_trap, b_pce, b_pcl, b_re1, b_re2, b_we, b_as1, b_as2, b_tl;
  logic        b_mas, b_il, b_ims;
  logic [4:0]  b_aop;
  logic [1:0]  b_wd, b_mwo;
  logic [2:0]  b_mro;
  logic [1:0]  b_cnt;

  ctl_t a_obs, b_obs;
  assign a_obs = {a_halt, a_trap, a_pce, a_pcl, a_re1, a_re2, a_we, a_as1, a_as2, a_aop,
                  a_tl, a_wd, a_mas, a_mro, a_mwo, a_il, a_ims};
  assign b_obs = {b_halt, b_trap, b_pce, b_pcl, b_re1, b_re2, b_we, b_as1, b_as2, b_aop,
                  b_tl, b_wd, b_mas, b_mro, b_mwo, b_il, b_ims};

  int checks = 0;
  int failures = 0;
  sb_t sbq[$];

  always #5 clk = ~clk;

  control_mc u_a (
    .clk(clk), .reset(a_rst), .opcode(opcode), .funct3(funct3), .bit20(bit20),
    .bit30(bit30), .cmp_out(cmp_out), .mem_ready(mem_ready), .halt(a_halt), .trap(a_trap),
    .pc_enable(a_pce), .pc_load(a_pcl), .reg_re1(a_re1), .reg_re2(a_re2), .reg_we(a_we),
    .alu_sel1(a_as1), .alu_sel2(a_as2), .alu_op(a_aop), .target_load(a_tl), .wd_sel(a_wd),
    .mem_addr_sel(a_mas), .mem_read_op(a_mro), .mem_write_op(a_mwo), .inst_load(a_il),
    .inst_mux_sel(a_ims), .instret(a_cnt)
  );

  control_mc #(.SKIP_MEM(1'b0), .MEM_TIMEOUT(4), .ILLEGAL_TRAP(1'b0), .CNT_WIDTH(2)) u_b (
    .clk(clk), .reset(b_rst), .opcode(opcode), .funct3(funct3), .bit20(bit20),
    .bit30(bit30), .cmp_out(cmp_out), .mem_ready(mem_ready), .halt(b_halt), .trap(b_trap),
    .pc_enable(b_pce), .pc_load(b_pcl), .reg_re1(b_re1), .reg_re2(b_re2), .reg_we(b_we),
    .alu_sel1(b_as1), .alu_sel2(b_as2), .alu_op(b_aop), .target_load(b_tl), .wd_sel(b_wd),
    .mem_addr_sel(b_mas), .mem_read_op(b_mro), .mem_write_op(b_mwo), .inst_load(b_il),
    .inst_mux_sel(b_ims), .instret(b_cnt)
  );

  function automatic ctl_t idle(input logic [6:0] opc);
    ctl_t e;
    e = '0;
    e.mem_read_op  = LNONE;
    e.mem_write_op = SNONE;
    e.wd_sel       = (opc == OP_LOAD) ? 2'b11 : 2'b00;
    return e;
  endfunction

  function automatic ctl_t e_fetch(input logic [6:0] opc);
    ctl_t e;
    e = idle(opc);
    e.mem_read_op = LW;
    return e;
  endfunction

  function automatic ctl_t e_decode(input logic [6:0] opc);
    ctl_t e;
    e = idle(opc);
    e.reg_re1 = 1'b1; e.reg_re2 = 1'b1; e.inst_load = 1'b1; e.target_load = 1'b1;
    e.alu_sel1 = 1'b1; e.alu_sel2 = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_mem(input logic [6:0] opc);
    ctl_t e;
    e = idle(opc);
    e.mem_addr_sel = 1'b1; e.inst_mux_sel = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_exec(input logic [6:0] opc);
    ctl_t e;
    e = idle(opc);
    e.inst_mux_sel = 1'b1; e.pc_enable = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_halt(input logic [6:0] opc);
    ctl_t e;
    e = idle(opc);
    e.halt = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_trap(input logic [6:0] opc);
    ctl_t e;
    e = idle(opc);
    e.trap = 1'b1;
    return e;
  endfunction

  task automatic set_in(input logic [6:0] opc, input logic [2:0] f3, input logic b20,
                        input logic b30, input logic cmp, input logic rdy);
    opcode = opc; funct3 = f3; bit20 = b20; bit30 = b30; cmp_out = cmp; mem_ready = rdy;
  endtask

  // Called at a falling edge with inputs applied; compares 1 time unit later.
  task automatic chk(input string tag, input bit on_b, input ctl_t e, input logic [31:0] cnt);
    sb_t s;
    ctl_t obs;
    logic [31:0] ocnt;
    s.tag = tag; s.on_b = on_b; s.exp = e; s.cnt = cnt;
    sbq.push_back(s);
    #1;
    s = sbq.pop_front();
    obs  = s.on_b ? b_obs : a_obs;
    ocnt = s.on_b ? {30'd0, b_cnt} : a_cnt;
    checks++;
    assert (obs === s.exp) else begin
      failures++;
      $error("FAIL %s ctl observed=%h expected=%h", s.tag, obs, s.exp);
    end
    checks++;
    assert (ocnt === s.cnt) else begin
      failures++;
      $error("FAIL %s instret observed=%0d expected=%0d", s.tag, ocnt, s.cnt);
    end
    @(negedge clk);
  endtask

  task automatic run_a(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                       input logic b20, input logic b30, input logic cmp, input ctl_t ex,
                       input logic [31:0] cnt);
    set_in(opc, f3, b20, b30, cmp, 1'b1);
    chk({tag, "_fetch"}, 1'b0, e_fetch(opc), cnt);
    chk({tag, "_decode"}, 1'b0, e_decode(opc), cnt);
    chk({tag, "_exec"}, 1'b0, ex, cnt);
  endtask

  task automatic run_b(input string tag, input logic [6:0] opc, input ctl_t ex,
                       input logic [31:0] cnt);
    set_in(opc, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk({tag, "_fetch"}, 1'b1, e_fetch(opc), cnt);
    chk({tag, "_decode"}, 1'b1, e_decode(opc), cnt);
    chk({tag, "_mem"}, 1'b1, e_mem(opc), cnt);
    chk({tag, "_exec"}, 1'b1, ex, cnt);
  endtask

  initial begin
    ctl_t e;
    set_in(OP_OPIMM, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    a_rst = 1'b1;
    b_rst = 1'b1;
    chk("a_reset", 1'b0, e_fetch(OP_OPIMM), 0);
    chk("b_reset", 1'b1, e_fetch(OP_OPIMM), 0);
    a_rst = 1'b0;

    e = e_exec(OP_OPIMM); e.reg_we = 1'b1; e.alu_sel2 = 1'b1;
    run_a("addi", OP_OPIMM, 3'b000, 1'b0, 1'b0, 1'b0, e, 0);
    e.alu_op = 5'b01101;
    run_a("srai", OP_OPIMM, 3'b101, 1'b0, 1'b1, 1'b0, e, 1);
    e.alu_op = 5'b00000;
    run_a("addi_b30", OP_OPIMM, 3'b000, 1'b0, 1'b1, 1'b0, e, 2);
    e = e_exec(OP_OP); e.reg_we = 1'b1; e.alu_op = 5'b01000;
    run_a("sub", OP_OP, 3'b000, 1'b0, 1'b1, 1'b0, e, 3);

    set_in(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lw_fetch", 1'b0, e_fetch(OP_LOAD), 4);
    chk("lw_decode", 1'b0, e_decode(OP_LOAD), 4);
    e = e_mem(OP_LOAD); e.mem_read_op = 3'b010; e.alu_sel2 = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) chk("lw_mem_stall", 1'b0, e, 4);
    mem_ready = 1'b1;
    chk("lw_mem_ready", 1'b0, e, 4);
    e = e_exec(OP_LOAD); e.reg_we = 1'b1;
    chk("lw_exec", 1'b0, e, 4);

    e = e_exec(OP_BRANCH); e.pc_load = 1'b1; e.alu_op = 5'b10000;
    run_a("beq_taken", OP_BRANCH, 3'b000, 1'b0, 1'b0, 1'b1, e, 5);
    e.pc_load = 1'b0;
    run_a("beq_not", OP_BRANCH, 3'b000, 1'b0, 1'b0, 1'b0, e, 6);

    e = e_exec(OP_SYSTEM); e.pc_enable = 1'b0;
    run_a("ebreak", OP_SYSTEM, 3'b000, 1'b1, 1'b0, 1'b0, e, 7);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      chk("halt_hold", 1'b0, e_halt(OP_SYSTEM), 7);
    end
    #3;
    a_rst = 1'b1;
    chk("a_async_reset", 1'b0, e_fetch(OP_SYSTEM), 0);
    a_rst = 1'b0;

    set_in(OP_ILL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ill_fetch", 1'b0, e_fetch(OP_ILL), 0);
    chk("ill_decode", 1'b0, e_decode(OP_ILL), 0);
    for (int i = 0; i < 3; i++) begin
      mem_ready = i[0];
      chk("ill_trap", 1'b0, e_trap(OP_ILL), 0);
    end
    a_rst = 1'b1;
    b_rst = 1'b0;

    set_in(OP_OPIMM, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) chk("b_fetch_stall", 1'b1, e_fetch(OP_OPIMM), 0);
    mem_ready = 1'b1;
    chk("b_fetch_ready_at_limit", 1'b1, e_fetch(OP_OPIMM), 0);
    chk("b_decode", 1'b1, e_decode(OP_OPIMM), 0);
    mem_ready = 1'b0;
    chk("b_mem_nonmem", 1'b1, e_mem(OP_OPIMM), 0);
    e = e_exec(OP_OPIMM); e.reg_we = 1'b1; e.alu_sel2 = 1'b1;
    chk("b_exec", 1'b1, e, 0);

    run_b("b_ill_nop", OP_ILL, e_exec(OP_ILL), 1);
    run_b("b_addi2", OP_OPIMM, e, 2);
    run_b("b_addi3", OP_OPIMM, e, 3);

    set_in(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sw_fetch_wrapped", 1'b1, e_fetch(OP_STORE), 0);
    chk("sw_decode", 1'b1, e_decode(OP_STORE), 0);
    e = e_mem(OP_STORE); e.mem_write_op = 2'b10; e.alu_sel2 = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) chk("sw_mem_stall", 1'b1, e, 0);
    chk("sw_timeout_trap", 1'b1, e_trap(OP_STORE), 0);
    mem_ready = 1'b1;
    chk("trap_sticky", 1'b1, e_trap(OP_STORE), 0);
    b_rst = 1'b1;
    chk("b_reset_from_trap", 1'b1, e_fetch(OP_STORE), 0);
    b_rst = 1'b0;

    set_in(OP_OPIMM, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) chk("b_fetch_stall_to", 1'b1, e_fetch(OP_OPIMM), 0);
    chk("b_fetch_timeout_trap", 1'b1, e_trap(OP_OPIMM), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_mc.md
Name: control_mc

Overview:
- Parametrised multicycle control FSM for the RV32I core; successor to the fixed four-step sequencer.
- Sequences FETCH/DECODE/MEM/EXEC but stalls on a memory ready handshake and optionally bypasses MEM for non-memory instructions.
- Adds sticky HALT and TRAP states (illegal opcode, bus timeout) and a retired-instruction counter.
- Drives the datapath: PC, register file, ALU muxes, memory port, instruction register.

Parameters:
- SKIP_MEM, 1, 1: DECODE goes straight to EXEC unless opcode is LOAD, STORE or JALR. 0: every instruction visits MEM.
- MEM_TIMEOUT, 16, max stall cycles in FETCH or MEM before TRAP. 0 disables the timeout.
- ILLEGAL_TRAP, 1, 1: an unrecognised opcode in DECODE enters TRAP. 0: treated as a NOP.
- CNT_WIDTH, 32, width of instret.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  instruction register [6:0]
- funct3  in  3  instruction [14:12]
- bit20  in  1  instruction [20]
- bit30  in  1  instruction [30]
- cmp_out  in  1  branch comparator result
- mem_ready  in  1  memory access complete this cycle
- halt  out  1  high in HALT state
- trap  out  1  high in TRAP state
- pc_enable, pc_load  out  1,1  PC update / load target
- reg_re1, reg_re2, reg_we  out  1,1,1  register file controls
- alu_sel1, alu_sel2  out  1,1  ALU operand selects
- alu_op  out  5  {branch, bit30-mod, funct3}
- target_load  out  1  target register load
- wd_sel  out  2  writeback select (00 ALU, 01 link, 11 load)
- mem_addr_sel  out  1  1 = data address, 0 = PC
- mem_read_op  out  3  LW/LB/…/LNONE from the shared defs include
- mem_write_op  out  2  SB/SH/SW/SNONE
- inst_load, inst_mux_sel  out  1,1  instruction register load / mux
- instret  out  CNT_WIDTH  retired instruction count

Behaviour:
- Reset (async, any state): state=FETCH, stall counter=0, instret=0.
  - Outputs at reset: mem_read_op=LW, mem_write_op=SNONE, alu_op=0, alu_sel=0/0; all enables, halt and trap 0.
  - wd_sel is decoded combinationally from opcode in all states.
- FETCH: mem_read_op=LW, mem_addr_sel=0. Hold FETCH until mem_ready. On mem_ready go to DECODE.
- DECODE (1 cycle): reg_re1=reg_re2=1, inst_load=1, target_load=1, alu_sel1=alu_sel2=1.
  - Next state: TRAP if ILLEGAL_TRAP and opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM, MISC_MEM.
  - Otherwise MEM if SKIP_MEM=0 or opcode is LOAD/STORE/JALR; else EXEC.
- MEM: mem_addr_sel=1, inst_mux_sel=1.
  - LOAD: mem_read_op=funct3. STORE: mem_write_op=funct3[1:0]. Both held stable until mem_ready.
  - Non-memory ops advance next cycle without waiting.
  - JALR: target_load=1.
  - LOAD/STORE/JALR: alu_sel=0/1.
- EXEC (1 cycle): inst_mux_sel=1.
  - reg_we for OP_IMM, LUI, OP, AUIPC, JAL, JALR, LOAD.
  - pc_enable=!halt_cond, where halt_cond = opcode==SYSTEM && bit20.
  - pc_load for JAL, JALR, or BRANCH with cmp_out=1.
  - alu_sel: AUIPC 1/1; OP_IMM and LUI 0/1; else 0/0.
  - alu_op: OP and shift-right OP_IMM {0,bit30,funct3}; other OP_IMM {0,0,funct3}; BRANCH {1,0,funct3}; else 0.
  - Next state: HALT if halt_cond, else FETCH.
  - instret += 1 on every EXEC except halt_cond; wraps modulo 2^CNT_WIDTH.
- Stall timeout: counter increments each FETCH/MEM cycle without mem_ready and clears on state change.
  - If MEM_TIMEOUT>0 and counter reaches MEM_TIMEOUT-1 without mem_ready, next state is TRAP.
  - mem_ready in that same cycle wins (normal advance).
- HALT and TRAP are sticky until reset. All enables are 0, mem ops are LNONE/SNONE, instret is frozen.
- No write strobe or register write is ever issued in TRAP or HALT, including on the entry cycle.

Test Plan:
- mem_ready tied 1, ADDI (OP_IMM, funct3=000), SKIP_MEM=1 -> FETCH, DECODE, EXEC; reg_we=1 in cycle 3; instret=1 after cycle 3.
- LW, mem_ready low for 3 cycles in MEM -> mem_read_op=010 held for 4 cycles; reg_we=1 and wd_sel=11 in following EXEC.
- BEQ with cmp_out=1 then cmp_out=0 -> alu_op=10000 in EXEC both times; pc_load=1 only the first; pc_enable=1 both.
- ECALL/EBREAK with bit20=1 -> halt=1 after EXEC, pc_enable=0, instret unchanged; state remains HALT for 20 cycles; async reset returns to FETCH with instret=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> trap=1 after 4 stall cycles; mem_ready asserted exactly on cycle 4 -> DECODE, no trap.
- opcode=7'h7F with ILLEGAL_TRAP=1 -> TRAP after DECODE, reg_we never asserted. With ILLEGAL_TRAP=0 -> EXEC with all enables 0 except pc_enable; instret increments.
